// File: rtl/score_ssd.sv
// Score keeper for a simple game: BCD score with saturation, high-score latch,
// and a multiplexed 4-digit seven-segment display that blinks when the game is over.
module score_ssd #(
    parameter int unsigned REFRESH_BITS = 18,
    parameter int unsigned FLASH_BITS   = 25
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        inc,
    input  logic        fail,
    input  logic        restart,
    output logic [6:0]  ssdOut,
    output logic [3:0]  anode,
    output logic [15:0] score,
    output logic [15:0] best,
    output logic        game_over
);

    localparam int unsigned SCORE_W = 16;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIG_N   = 4;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [SCORE_W-1:0]      r_score;
    logic [SCORE_W-1:0]      r_best;
    logic [SCORE_W-1:0]      w_score_next;
    logic [SCORE_W-1:0]      w_best_next;
    logic [SCORE_W-1:0]      w_score_inc;
    logic [REFRESH_BITS-1:0] r_refresh;
    logic [FLASH_BITS-1:0]   r_blink;
    logic [FLASH_BITS-1:0]   w_blink_next;
    logic [1:0]              w_sel;
    logic [3:0]              w_digit;
    logic [DIG_N-1:0]        w_vis;
    logic                    w_blank;
    logic [DIG_N-1:0]        w_anode_next;
    logic [SEG_W-1:0]        w_glyph;
    logic [DIG_N-1:0]        r_anode;
    logic [SEG_W-1:0]        r_ssd;

    // BCD +1 with carry rippling through all four digits
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] res;
        logic               carry;
        logic [3:0]         nib;
        res   = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            nib = v[4*d +: 4];
            if (carry) begin
                if (nib == 4'd9) begin
                    res[4*d +: 4] = 4'd0;
                end else begin
                    res[4*d +: 4] = 4'(nib + 4'd1);
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

    assign w_score_inc = bcd_inc(r_score);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= PLAY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, score, high score and blink counter
    always_comb begin
        w_state_next = r_state;
        w_score_next = r_score;
        w_best_next  = r_best;
        w_blink_next = '0;
        case (r_state)
            PLAY: begin
                if (restart) begin
                    w_score_next = '0;
                end else begin
                    if (inc && (r_score != SCORE_MAX)) begin
                        w_score_next = w_score_inc;
                    end
                    if (fail) begin
                        w_state_next = OVER;
                        w_best_next  = (w_score_next > r_best) ? w_score_next : r_best;
                    end
                end
            end
            OVER: begin
                if (restart) begin
                    w_score_next = '0;
                    w_state_next = PLAY;
                end else begin
                    w_blink_next = r_blink + FLASH_BITS'(1);
                end
            end
            default: begin
                w_state_next = PLAY;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_score   <= '0;
            r_best    <= '0;
            r_blink   <= '0;
            r_refresh <= '0;
        end else begin
            r_score   <= w_score_next;
            r_best    <= w_best_next;
            r_blink   <= w_blink_next;
            r_refresh <= r_refresh + REFRESH_BITS'(1);
        end
    end

    // Digit select, leading-zero blanking and game-over blink
    assign w_sel    = r_refresh[REFRESH_BITS-1 -: 2];
    assign w_vis[0] = 1'b1;
    assign w_vis[1] = |r_score[15:4];
    assign w_vis[2] = |r_score[15:8];
    assign w_vis[3] = |r_score[15:12];
    assign w_blank  = (r_state == OVER) && r_blink[FLASH_BITS-1];

    always_comb begin
        w_digit = r_score[3:0];
        case (w_sel)
            2'd0:    w_digit = r_score[3:0];
            2'd1:    w_digit = r_score[7:4];
            2'd2:    w_digit = r_score[11:8];
            2'd3:    w_digit = r_score[15:12];
            default: w_digit = r_score[3:0];
        endcase
    end

    always_comb begin
        w_anode_next = 4'b1111;
        if (w_vis[w_sel] && !w_blank) begin
            w_anode_next = ~(4'b0001 << w_sel);
        end
    end

    always_comb begin
        w_glyph = 7'b1111111;
        case (w_digit)
            4'd0:    w_glyph = 7'b0000001;
            4'd1:    w_glyph = 7'b1001111;
            4'd2:    w_glyph = 7'b0010010;
            4'd3:    w_glyph = 7'b0000110;
            4'd4:    w_glyph = 7'b1001100;
            4'd5:    w_glyph = 7'b0100100;
            4'd6:    w_glyph = 7'b0100000;
            4'd7:    w_glyph = 7'b0001111;
            4'd8:    w_glyph = 7'b0000000;
            4'd9:    w_glyph = 7'b0000100;
            default: w_glyph = 7'b1111111;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_anode <= 4'b1111;
            r_ssd   <= 7'b1111111;
        end else begin
            r_anode <= w_anode_next;
            r_ssd   <= w_glyph;
        end
    end

    assign ssdOut    = r_ssd;
    assign anode     = r_anode;
    assign score     = r_score;
    assign best      = r_best;
    assign game_over = (r_state == OVER);

endmodule

// File: tb/tb_score_ssd.sv
// Directed bench for score_ssd with small refresh/blink counters.
module tb_score_ssd;

    logic        Clk;
    logic        Reset;
    logic        inc;
    logic        fail;
    logic        restart;
    logic [6:0]  ssdOut;
    logic [3:0]  anode;
    logic [15:0] score;
    logic [15:0] best;
    logic        game_over;

    int checks = 0;
    int errors = 0;
    logic [3:0] m_ref;

    score_ssd #(.REFRESH_BITS(4), .FLASH_BITS(4)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .inc       (inc),
        .fail      (fail),
        .restart   (restart),
        .ssdOut    (ssdOut),
        .anode     (anode),
        .score     (score),
        .best      (best),
        .game_over (game_over)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference refresh counter: free-running from reset release
    always @(posedge Clk) begin
        if (Reset) m_ref <= 4'd0;
        else       m_ref <= m_ref + 4'd1;
    end

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: glyph = 7'b0000001;
            4'd1: glyph = 7'b1001111;
            4'd2: glyph = 7'b0010010;
            4'd3: glyph = 7'b0000110;
            4'd4: glyph = 7'b1001100;
            4'd5: glyph = 7'b0100100;
            4'd6: glyph = 7'b0100000;
            4'd7: glyph = 7'b0001111;
            4'd8: glyph = 7'b0000000;
            4'd9: glyph = 7'b0000100;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic pulse_inc(input int n);
        for (int k = 0; k < n; k++) begin
            inc = 1'b1;
            step();
        end
        inc = 1'b0;
    endtask

    // Checks n display cycles; blink=1 means the first cycle shows blink count 0 in OVER
    task automatic disp_chk(input string tag, input int n, input logic [15:0] sc,
                            input logic [3:0] vis, input bit blink);
        logic [3:0] r;
        logic [3:0] exp_an;
        logic [3:0] dig;
        int         sel;
        bit         on;
        for (int i = 0; i < n; i++) begin
            step();
            r      = m_ref - 4'd1;
            sel    = int'(r[3:2]);
            on     = vis[sel] && !(blink && ((i & 8) != 0));
            exp_an = on ? ~(4'b0001 << sel) : 4'b1111;
            dig    = 4'(sc >> (4 * sel));
            chk({tag, "_anode"}, 16'(anode), 16'(exp_an));
            if (on) chk({tag, "_ssd"}, 16'(ssdOut), 16'(glyph(dig)));
        end
    endtask

    initial begin
        Reset = 1'b1; inc = 1'b0; fail = 1'b0; restart = 1'b0;
        repeat (2) step();
        chk("rst_score", score, 16'h0000);
        chk("rst_best", best, 16'h0000);
        chk("rst_go", 16'(game_over), 16'h0000);
        chk("rst_anode", 16'(anode), 16'h000F);
        chk("rst_ssd", 16'(ssdOut), 16'h007F);

        Reset = 1'b0;
        step();
        chk("first_anode", 16'(anode), 16'h000E);
        chk("first_ssd", 16'(ssdOut), 16'(7'b0000001));
        disp_chk("zero", 16, 16'h0000, 4'b0001, 1'b0);

        pulse_inc(105);
        chk("score_105", score, 16'h0105);
        disp_chk("d105", 16, 16'h0105, 4'b0111, 1'b0);

        pulse_inc(9893);
        chk("score_9998", score, 16'h9998);
        pulse_inc(3);
        chk("score_sat", score, 16'h9999);
        chk("go_play", 16'(game_over), 16'h0000);
        disp_chk("d9999", 16, 16'h9999, 4'b1111, 1'b0);

        restart = 1'b1; step(); restart = 1'b0;
        chk("restart_score", score, 16'h0000);
        chk("restart_best", best, 16'h0000);
        pulse_inc(42);
        chk("score_42", score, 16'h0042);

        inc = 1'b1; fail = 1'b1; step(); inc = 1'b0; fail = 1'b0;
        chk("incfail_score", score, 16'h0043);
        chk("incfail_go", 16'(game_over), 16'h0001);
        chk("incfail_best", best, 16'h0043);
        inc = 1'b1;
        disp_chk("blink", 32, 16'h0043, 4'b0011, 1'b1);
        inc = 1'b0;
        chk("over_hold", score, 16'h0043);

        restart = 1'b1; step(); restart = 1'b0;
        chk("rs2_score", score, 16'h0000);
        chk("rs2_go", 16'(game_over), 16'h0000);
        chk("rs2_best", best, 16'h0043);
        pulse_inc(10);
        chk("score_10", score, 16'h0010);
        fail = 1'b1; step(); fail = 1'b0;
        chk("low_go", 16'(game_over), 16'h0001);
        chk("low_best", best, 16'h0043);
        chk("low_score", score, 16'h0010);

        restart = 1'b1; step(); restart = 1'b0;
        pulse_inc(7);
        chk("score_7", score, 16'h0007);
        restart = 1'b1; fail = 1'b1; step(); restart = 1'b0; fail = 1'b0;
        chk("rsfail_score", score, 16'h0000);
        chk("rsfail_go", 16'(game_over), 16'h0000);
        chk("rsfail_best", best, 16'h0043);
        pulse_inc(3);
        inc = 1'b1; restart = 1'b1; step(); inc = 1'b0; restart = 1'b0;
        chk("rsinc_score", score, 16'h0000);

        fail = 1'b1; step(); fail = 1'b0;
        chk("over3_go", 16'(game_over), 16'h0001);
        chk("over3_best", best, 16'h0043);
        Reset = 1'b1; inc = 1'b1; step(); Reset = 1'b0; inc = 1'b0;
        chk("rst2_best", best, 16'h0000);
        chk("rst2_score", score, 16'h0000);
        chk("rst2_go", 16'(game_over), 16'h0000);
        chk("rst2_anode", 16'(anode), 16'h000F);
        chk("rst2_ssd", 16'(ssdOut), 16'h007F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
